// File: rtl/ratio_pkg.sv
// ratio_pkg: FSM encodings and operation selectors shared by the ratio engine
package ratio_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_DIV, S_DONE} state_t;
  localparam logic OP_PQ_RATIO = 1'b0;
  localparam logic OP_SUM_DIFF = 1'b1;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per cycle; quo/rem carry the value the current step registers
module seq_divider #(
  parameter int DW = 48,
  parameter int VW = 25
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quo,
  output logic [VW-1:0] rem
);
  localparam int CW = $clog2(DW + 1);
  logic [DW-1:0] q_r;
  logic [VW-1:0] r_r, d_r;
  logic [CW-1:0] cnt;
  logic [VW:0] sh;
  logic ge;
  always_comb begin
    sh = {r_r, q_r[DW-1]};
    ge = sh >= {1'b0, d_r};
    rem = ge ? VW'(sh - {1'b0, d_r}) : sh[VW-1:0];
    quo = {q_r[DW-2:0], ge};
    busy = cnt != '0;
    done = cnt == CW'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_r <= '0;
      r_r <= '0;
      d_r <= '0;
      cnt <= '0;
    end else if (load) begin
      q_r <= dividend;
      r_r <= '0;
      d_r <= divisor;
      cnt <= CW'(DW);
    end else if (busy) begin
      q_r <= quo;
      r_r <= rem;
      cnt <= cnt - CW'(1);
    end
endmodule

// File: rtl/ratio_engine.sv
// ratio_engine: sequential (P*Q)/(P+Q) or (P+Q)/(R-Q) unit; RATIO_HIST_EN adds a circular result history
module ratio_engine
  import ratio_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sel,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH:0]   rem,
  output logic             div_zero,
  output logic             ovf,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH+1:0] rd_data,
  output logic [AW:0]      hist_count
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_nxt;
  logic op_r;
  logic [WIDTH-1:0] p_r, q_r, r_r, mq;
  logic [2*WIDTH-1:0] mc, acc, acc_nxt, dv_dnd, dv_quo;
  logic [CW-1:0] mcnt;
  logic [WIDTH:0] num, dvs, dv_rem;
  logic dv_zero, mul_last, dv_load, dv_busy, dv_done, dv_ovf;
  assign num = {1'b0, p_r} + {1'b0, q_r};
  assign dvs = (op_r == OP_PQ_RATIO) ? num : {1'b0, r_r - q_r};
  assign dv_zero = dvs == '0;
  assign mul_last = state == S_MUL && mcnt == CW'(1);
  assign acc_nxt = acc + (mq[0] ? mc : '0);
  assign dv_load = (state == S_LOAD && !dv_zero && op_r == OP_SUM_DIFF) || mul_last;
  assign dv_dnd = mul_last ? acc_nxt : {{(WIDTH-1){1'b0}}, num};
  assign dv_ovf = |dv_quo[2*WIDTH-1:WIDTH];
  seq_divider #(.DW(2*WIDTH), .VW(WIDTH+1)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .load(dv_load),
    .dividend(dv_dnd),
    .divisor(dvs),
    .busy(dv_busy),
    .done(dv_done),
    .quo(dv_quo),
    .rem(dv_rem)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = start ? S_LOAD : S_IDLE;
      S_LOAD: state_nxt = dv_zero ? S_DONE : (op_r == OP_SUM_DIFF) ? S_DIV : S_MUL;
      S_MUL:  state_nxt = mul_last ? S_DIV : S_MUL;
      S_DIV:  state_nxt = dv_done ? S_DONE : S_DIV;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    busy = state == S_LOAD || state == S_MUL || dv_busy;
    done = state == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_r <= 1'b0;
      p_r <= '0;
      q_r <= '0;
      r_r <= '0;
      mc <= '0;
      mq <= '0;
      acc <= '0;
      mcnt <= '0;
    end else begin
      if (state == S_IDLE && start) {op_r, p_r, q_r, r_r} <= {op_sel, p, q, r};
      if (state == S_LOAD) begin
        mc <= {{WIDTH{1'b0}}, p_r};
        mq <= q_r;
        acc <= '0;
        mcnt <= CW'(WIDTH);
      end else if (state == S_MUL) begin
        acc <= acc_nxt;
        mc <= mc << 1;
        mq <= mq >> 1;
        mcnt <= mcnt - CW'(1);
      end
    end
  // results register on the edge entering DONE so they are valid alongside done
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s <= '0;
      rem <= '0;
      div_zero <= 1'b0;
      ovf <= 1'b0;
    end else if (state == S_LOAD && dv_zero) begin
      s <= '1;
      rem <= '0;
      div_zero <= 1'b1;
      ovf <= 1'b0;
    end else if (state == S_DIV && dv_done) begin
      s <= dv_ovf ? '1 : dv_quo[WIDTH-1:0];
      rem <= dv_rem;
      div_zero <= 1'b0;
      ovf <= dv_ovf;
    end
`ifdef RATIO_HIST_EN
  logic [WIDTH+1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  always_ff @(posedge clk)
    if (done) mem[wr_ptr] <= {ovf, div_zero, s};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      hist_count <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      if (done) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (hist_count != (AW+1)'(DEPTH)) hist_count <= hist_count + (AW+1)'(1);
      end
    end
`else
  logic unused_rd;
  assign unused_rd = ^rd_addr;
  assign rd_data = '0;
  assign hist_count = '0;
`endif
endmodule

// File: doc/ratio_engine.md
# ratio_engine

- Parametrised sequential arithmetic unit that evaluates one of two selectable ratio expressions on three unsigned operands.
  - Mode 0: (P·Q)/(P+Q).
  - Mode 1: (P+Q)/(R−Q).
- A shift-add multiplier and a restoring divider share one FSM, behind a start/done handshake.
- Flags divide-by-zero and quotient overflow.
- Optionally logs every result in a circular history buffer for later readout by the datapath controller.

## Interface
Parameters:
- WIDTH, 24, operand/result width.
- DEPTH, 16, history entries; power of two. AW = log2(DEPTH) is derived.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op_sel  in  1  0 = (P·Q)/(P+Q), 1 = (P+Q)/(R−Q); latched with start.
- p, q, r  in  WIDTH  operands; latched with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; s/rem/flags valid from this cycle until the next done.
- s  out  WIDTH  quotient.
- rem  out  WIDTH+1  remainder.
- div_zero  out  1  divisor was zero.
- ovf  out  1  quotient exceeded WIDTH bits.
- rd_addr  in  AW  history read address (absolute slot).
- rd_data  out  WIDTH+2  {ovf, div_zero, s} of the slot; registered.
- hist_count  out  AW+1  valid entries, saturating at DEPTH.

## Operation
- States: IDLE, LOAD, MUL, DIV, DONE.
- IDLE → LOAD on start. start is ignored outside IDLE.
- LOAD latches the operands, then forms the numerator and divisor:
  - numerator = P+Q, computed WIDTH+1 bits, no wrap.
  - divisor = P+Q (mode 0) or R−Q modulo 2^WIDTH, zero-extended to WIDTH+1 (mode 1).
- LOAD transitions:
  - divisor == 0 → DONE.
  - mode 0 → MUL.
  - mode 1 → DIV.
- MUL: WIDTH cycles, one partial product bit per cycle, giving a 2·WIDTH product used as the dividend.
- DIV: 2·WIDTH cycles, one quotient bit per cycle, on a 2·WIDTH dividend and a WIDTH+1 divisor.
- DONE: one cycle, then → IDLE. Results update and done pulses here.
- Divide by zero: s = all ones, rem = 0, div_zero = 1, ovf = 0.
- Overflow (quotient ≥ 2^WIDTH, mode 1 only): s = all ones, rem = true remainder, ovf = 1. Mode 0 cannot overflow since the result is ≤ min(P,Q).
- History:
  - On each done, {ovf, div_zero, s} is written to slot wr_ptr, then wr_ptr increments, wrapping DEPTH−1 → 0.
  - When full, the oldest entry is overwritten and hist_count stays at DEPTH.

## Timing
- Reset values: busy 0, done 0, s 0, rem 0, div_zero 0, ovf 0, hist_count 0, rd_data 0, wr_ptr 0. History contents are undefined.
- Latency, measured from the edge that samples start to the first edge where done is high:
  - mode 0: 3·WIDTH+2 (74 at WIDTH=24).
  - mode 1: 2·WIDTH+2 (50).
  - zero divisor: 2.
- Throughput: a new start is accepted in the cycle after done.
- rd_data is valid one cycle after rd_addr. A read of the slot being written in the same cycle returns the old contents.
- rst_n low mid-operation aborts immediately: FSM → IDLE and all outputs go to reset values. No history write occurs.

## Configuration
- RATIO_HIST_EN:
  - Defined: history buffer, wr_ptr and hist_count are built.
  - Undefined: none of these exist; rd_data and hist_count are tied to 0 and rd_addr is unused.

## Structure
- Package ratio_pkg holds:
  - FSM state encodings.
  - OP_PQ_RATIO = 1'b0, OP_SUM_DIFF = 1'b1.
- One sub-module, seq_divider: restoring divider with load/busy/done, parametrised on dividend and divisor width.
- Multiplier and FSM remain in ratio_engine.

## Test plan
All at WIDTH=24, DEPTH=16, RATIO_HIST_EN defined.
- op_sel=0, P=6, Q=3 → done at cycle 74; s=2, rem=0, flags 0.
- op_sel=1, P=10, Q=5, R=8 → done at cycle 50; s=5, rem=0.
- op_sel=1, P=1, Q=7, R=7 → done at cycle 2; s=0xFFFFFF, div_zero=1.
- op_sel=1, P=0xFFFFFF, Q=1, R=2 → s=0xFFFFFF, ovf=1, rem=0.
- 17 back-to-back ops with s values 1..17 → hist_count=16; rd_addr=0 returns s=17, rd_addr=1 returns s=2.
- rst_n pulsed low 10 cycles into MUL → busy=0 at once, no done; next start with P=6, Q=3 gives s=2.
